// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: hazard/stall/flush controller for the 5-stage MIPS core.
// Arbitrates memory freeze > load-use stall > branch/jump redirect > run and
// drives the enables, flushes and bubbles of the PC and the four pipeline
// registers. Tracks memory wait length (sticky mem_timeout) and back-to-back
// load-use stalls (sticky stall_err).
// Optional feature: define PIPELINE_PERF_CNT_EN to build the three
// performance counters; otherwise they read as zero.
// Handshake note: there is no valid/ready pair here; mem_req_M/mem_ack_M is a
// request-held-until-ack protocol, and a request with ack in the same cycle
// completes without freezing the pipeline.
module pipeline_ctrl_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_D,
    input  logic             branch_taken_D,
    input  logic             jump_D,
    input  logic             mem_req_M,
    input  logic             mem_ack_M,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             stall_err,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [1:0]       fsm_state_o
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            stall_err_q, stall_err_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic stall_take;
    logic redirect;

    assign freeze     = mem_req_M & ~mem_ack_M;
    assign stall_take = stall_D & ~freeze;
    assign redirect   = (branch_taken_D | jump_D) & ~stall_D & ~freeze;

    // Next state, wait counter and sticky flag updates.
    always_comb begin
        state_d       = ST_RUN;
        wait_cnt_d    = '0;
        stall_err_d   = stall_err_q;
        mem_timeout_d = mem_timeout_q;
        if (freeze) begin
            state_d = ST_MEM_WAIT;
        end else if (stall_take) begin
            state_d = ST_LU_STALL;
        end
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
        end
        // Entering LU_STALL always means the stall was honoured last cycle.
        if ((state_q == ST_LU_STALL) && stall_take) begin
            stall_err_d = 1'b1;
        end
        if (wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
        end
    end

    // State, wait counter and sticky flags with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_err_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_err_q   <= stall_err_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Zero-latency pipeline controls; reset forces every stage to hold a NOP.
    always_comb begin
        pc_we        = ~freeze & ~stall_take;
        ifid_we      = ~freeze & ~stall_take;
        ifid_flush   = redirect;
        idex_bubble  = stall_take;
        idex_we      = ~freeze;
        exmem_we     = ~freeze;
        memwb_bubble = freeze;
        if (!rst_n) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    assign stall_err   = stall_err_q;
    assign mem_timeout = mem_timeout_q;
    assign fsm_state_o = state_q;

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall_take) stall_cnt_q  <= stall_cnt_q + 1'b1;
            if (redirect)   flush_cnt_q  <= flush_cnt_q + 1'b1;
            if (freeze)     freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign flush_cycles  = flush_cnt_q;
    assign freeze_cycles = freeze_cnt_q;
`else
    assign stall_cycles  = '0;
    assign flush_cycles  = '0;
    assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: directed test-plan steps followed by random steps,
// each checked against a cycle-level behavioural model of the controller.
module tb_pipeline_ctrl_unit;

  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_W       = 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst_n, stall_D, branch_taken_D, jump_D, mem_req_M, mem_ack_M;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble;
  logic stall_err, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_cycles, freeze_cycles;
  logic [1:0] fsm_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pipeline_ctrl_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_D(stall_D), .branch_taken_D(branch_taken_D),
    .jump_D(jump_D), .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_bubble(memwb_bubble), .stall_err(stall_err), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
    .freeze_cycles(freeze_cycles), .fsm_state_o(fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Model state: whether the previous cycle honoured a stall, length of the
  // current freeze run, sticky flags and event counts.
  bit               m_init = 0;
  bit               m_prev_stall;
  int               m_freeze_run;
  bit               m_stall_err, m_timeout;
  logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt, m_freeze_cnt;
  logic [CNT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, checks outputs mid-cycle, clocks, updates model.
  task automatic step(input logic rst, input logic s, input logic b, input logic j,
                      input logic rq, input logic ak);
    bit fz, st, rd;
    rst_n = rst; stall_D = s; branch_taken_D = b; jump_D = j;
    mem_req_M = rq; mem_ack_M = ak;
    #3;
    fz = rq & ~ak;
    st = s & ~fz;
    rd = (b | j) & ~s & ~fz;
    exp_q.delete();
    if (!rst) begin
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    end else begin
      exp_q.push_back(CNT_W'(!fz && !st));  // pc_we
      exp_q.push_back(CNT_W'(!fz && !st));  // ifid_we
      exp_q.push_back(CNT_W'(rd));          // ifid_flush
      exp_q.push_back(CNT_W'(st));          // idex_bubble
      exp_q.push_back(CNT_W'(!fz));         // idex_we
      exp_q.push_back(CNT_W'(!fz));         // exmem_we
      exp_q.push_back(CNT_W'(fz));          // memwb_bubble
    end
    chk("pc_we",        CNT_W'(pc_we),        exp_q.pop_front());
    chk("ifid_we",      CNT_W'(ifid_we),      exp_q.pop_front());
    chk("ifid_flush",   CNT_W'(ifid_flush),   exp_q.pop_front());
    chk("idex_bubble",  CNT_W'(idex_bubble),  exp_q.pop_front());
    chk("idex_we",      CNT_W'(idex_we),      exp_q.pop_front());
    chk("exmem_we",     CNT_W'(exmem_we),     exp_q.pop_front());
    chk("memwb_bubble", CNT_W'(memwb_bubble), exp_q.pop_front());
    if (m_init) begin
      chk("stall_err",   CNT_W'(stall_err),   CNT_W'(m_stall_err));
      chk("mem_timeout", CNT_W'(mem_timeout), CNT_W'(m_timeout));
`ifdef PIPELINE_PERF_CNT_EN
      chk("stall_cycles",  stall_cycles,  m_stall_cnt);
      chk("flush_cycles",  flush_cycles,  m_flush_cnt);
      chk("freeze_cycles", freeze_cycles, m_freeze_cnt);
`else
      chk("stall_cycles",  stall_cycles,  '0);
      chk("flush_cycles",  flush_cycles,  '0);
      chk("freeze_cycles", freeze_cycles, '0);
`endif
    end
    @(posedge clk);
    if (!rst) begin
      m_init = 1; m_prev_stall = 0; m_freeze_run = 0;
      m_stall_err = 0; m_timeout = 0;
      m_stall_cnt = '0; m_flush_cnt = '0; m_freeze_cnt = '0;
    end else if (m_init) begin
      if (m_prev_stall && st) m_stall_err = 1;
      m_prev_stall = st;
      m_freeze_run = fz ? m_freeze_run + 1 : 0;
      if (m_freeze_run >= MEM_TIMEOUT) m_timeout = 1;
      if (st) m_stall_cnt++;
      if (rd) m_flush_cnt++;
      if (fz) m_freeze_cnt++;
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, then idle.
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Single load-use stall, then run.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Stall together with branch: stall wins; branch alone next cycle redirects.
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1);  // single-cycle access, no freeze
    // Memory wait of 3 cycles with jump held; the ack cycle redirects.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 1);
    // Two consecutive stalls raise the sticky stall_err.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // Freeze of MEM_TIMEOUT cycles sets mem_timeout exactly at the boundary.
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, $urandom_range(0, 1), 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // Reset mid-wait: abandon the wait, clear flags.
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < MEM_TIMEOUT - 2; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0));
    end
    // Long random-ack-free freeze to exercise saturation after the timeout.
    for (int i = 0; i < MEM_TIMEOUT + 10; i++)
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
